// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I(M) decode stage: opcodes, ALU codes,
// operand-source types and the decoded bundle carried through the FIFO.
package decode_stage_pkg;

    localparam int ENABLE  = 1;
    localparam int DISABLE = 0;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    localparam logic [5:0] ALU_LUI    = 6'd0;
    localparam logic [5:0] ALU_JAL    = 6'd1;
    localparam logic [5:0] ALU_JALR   = 6'd2;
    localparam logic [5:0] ALU_BEQ    = 6'd3;
    localparam logic [5:0] ALU_BNE    = 6'd4;
    localparam logic [5:0] ALU_BLT    = 6'd5;
    localparam logic [5:0] ALU_BGE    = 6'd6;
    localparam logic [5:0] ALU_BLTU   = 6'd7;
    localparam logic [5:0] ALU_BGEU   = 6'd8;
    localparam logic [5:0] ALU_LB     = 6'd9;
    localparam logic [5:0] ALU_LH     = 6'd10;
    localparam logic [5:0] ALU_LW     = 6'd11;
    localparam logic [5:0] ALU_LBU    = 6'd12;
    localparam logic [5:0] ALU_LHU    = 6'd13;
    localparam logic [5:0] ALU_SB     = 6'd14;
    localparam logic [5:0] ALU_SH     = 6'd15;
    localparam logic [5:0] ALU_SW     = 6'd16;
    localparam logic [5:0] ALU_ADD    = 6'd17;
    localparam logic [5:0] ALU_SUB    = 6'd18;
    localparam logic [5:0] ALU_SLT    = 6'd19;
    localparam logic [5:0] ALU_SLTU   = 6'd20;
    localparam logic [5:0] ALU_XOR    = 6'd21;
    localparam logic [5:0] ALU_OR     = 6'd22;
    localparam logic [5:0] ALU_AND    = 6'd23;
    localparam logic [5:0] ALU_SLL    = 6'd24;
    localparam logic [5:0] ALU_SRL    = 6'd25;
    localparam logic [5:0] ALU_SRA    = 6'd26;
    localparam logic [5:0] ALU_NOP    = 6'd27;
    localparam logic [5:0] ALU_MUL    = 6'd32;
    localparam logic [5:0] ALU_MULH   = 6'd33;
    localparam logic [5:0] ALU_MULHSU = 6'd34;
    localparam logic [5:0] ALU_MULHU  = 6'd35;
    localparam logic [5:0] ALU_DIV    = 6'd36;
    localparam logic [5:0] ALU_DIVU   = 6'd37;
    localparam logic [5:0] ALU_REM    = 6'd38;
    localparam logic [5:0] ALU_REMU   = 6'd39;

    typedef enum logic [1:0] {
        OP_TYPE_NONE = 2'd0,
        OP_TYPE_REG  = 2'd1,
        OP_TYPE_IMM  = 2'd2,
        OP_TYPE_PC   = 2'd3
    } op_type_e;

    typedef struct packed {
        logic [4:0]  srcreg1_num;
        logic [4:0]  srcreg2_num;
        logic [4:0]  dstreg_num;
        logic [31:0] imm;
        logic [5:0]  alucode;
        op_type_e    aluop1_type;
        op_type_e    aluop2_type;
        logic        reg_wren;
        logic        is_load;
        logic        is_store;
        logic        is_halt;
        logic        is_illegal;
    } bundle_t;

    // funct3 of an M-extension OP instruction selects one of eight ALU codes
    function automatic logic [5:0] mAluCode(input logic [2:0] f3);
        logic [5:0] code;
        case (f3)
            3'd0:    code = ALU_MUL;
            3'd1:    code = ALU_MULH;
            3'd2:    code = ALU_MULHSU;
            3'd3:    code = ALU_MULHU;
            3'd4:    code = ALU_DIV;
            3'd5:    code = ALU_DIVU;
            3'd6:    code = ALU_REM;
            default: code = ALU_REMU;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/decode_stage_decode.sv
// Purely combinational RV32I(M) decoder: instruction word to decoded bundle,
// including illegal-encoding and ECALL detection.
module rv_decode_comb
    import decode_stage_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [31:0] i_ir,
    output bundle_t     o_bundle
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_immI;
    logic [31:0] w_immSh;
    logic [31:0] w_immS;
    logic [31:0] w_immB;
    logic [31:0] w_immJ;
    logic [31:0] w_immU;
    logic        w_legal;
    logic        w_writes;
    bundle_t     w_bundle;

    assign w_opcode = i_ir[6:0];
    assign w_rd     = i_ir[11:7];
    assign w_f3     = i_ir[14:12];
    assign w_rs1    = i_ir[19:15];
    assign w_rs2    = i_ir[24:20];
    assign w_f7     = i_ir[31:25];

    assign w_immI  = {{20{i_ir[31]}}, i_ir[31:20]};
    assign w_immSh = {27'b0, i_ir[24:20]};
    assign w_immS  = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
    assign w_immB  = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
    assign w_immJ  = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
    assign w_immU  = {i_ir[31:12], 12'b0};

    // Decode by opcode; anything unrecognised collapses to an all-zero illegal bundle
    always_comb begin
        w_bundle = '0;
        w_legal  = 1'b1;
        w_writes = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_bundle.alucode     = ALU_LUI;
                w_bundle.aluop2_type = OP_TYPE_IMM;
                w_bundle.imm         = w_immU;
                w_writes             = 1'b1;
            end
            OPC_AUIPC: begin
                w_bundle.alucode     = ALU_ADD;
                w_bundle.aluop1_type = OP_TYPE_IMM;
                w_bundle.aluop2_type = OP_TYPE_PC;
                w_bundle.imm         = w_immU;
                w_writes             = 1'b1;
            end
            OPC_JAL: begin
                w_bundle.alucode     = ALU_JAL;
                w_bundle.aluop2_type = OP_TYPE_PC;
                w_bundle.imm         = w_immJ;
                w_writes             = 1'b1;
            end
            OPC_JALR: begin
                w_bundle.alucode     = ALU_JALR;
                w_bundle.srcreg1_num = w_rs1;
                w_bundle.aluop1_type = OP_TYPE_REG;
                w_bundle.aluop2_type = OP_TYPE_IMM;
                w_bundle.imm         = w_immI;
                w_writes             = 1'b1;
                w_legal              = (w_f3 == 3'b000);
            end
            OPC_BRANCH: begin
                w_bundle.srcreg1_num = w_rs1;
                w_bundle.srcreg2_num = w_rs2;
                w_bundle.aluop1_type = OP_TYPE_REG;
                w_bundle.aluop2_type = OP_TYPE_REG;
                w_bundle.imm         = w_immB;
                case (w_f3)
                    3'b000:  w_bundle.alucode = ALU_BEQ;
                    3'b001:  w_bundle.alucode = ALU_BNE;
                    3'b100:  w_bundle.alucode = ALU_BLT;
                    3'b101:  w_bundle.alucode = ALU_BGE;
                    3'b110:  w_bundle.alucode = ALU_BLTU;
                    3'b111:  w_bundle.alucode = ALU_BGEU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                w_bundle.srcreg1_num = w_rs1;
                w_bundle.aluop1_type = OP_TYPE_REG;
                w_bundle.aluop2_type = OP_TYPE_IMM;
                w_bundle.imm         = w_immI;
                w_bundle.is_load     = 1'b1;
                w_writes             = 1'b1;
                case (w_f3)
                    3'b000:  w_bundle.alucode = ALU_LB;
                    3'b001:  w_bundle.alucode = ALU_LH;
                    3'b010:  w_bundle.alucode = ALU_LW;
                    3'b100:  w_bundle.alucode = ALU_LBU;
                    3'b101:  w_bundle.alucode = ALU_LHU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_bundle.srcreg1_num = w_rs1;
                w_bundle.srcreg2_num = w_rs2;
                w_bundle.aluop1_type = OP_TYPE_REG;
                w_bundle.aluop2_type = OP_TYPE_IMM;
                w_bundle.imm         = w_immS;
                w_bundle.is_store    = 1'b1;
                case (w_f3)
                    3'b000:  w_bundle.alucode = ALU_SB;
                    3'b001:  w_bundle.alucode = ALU_SH;
                    3'b010:  w_bundle.alucode = ALU_SW;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                w_bundle.srcreg1_num = w_rs1;
                w_bundle.aluop1_type = OP_TYPE_REG;
                w_bundle.aluop2_type = OP_TYPE_IMM;
                w_bundle.imm         = w_immI;
                w_writes             = 1'b1;
                case (w_f3)
                    3'b000: w_bundle.alucode = ALU_ADD;
                    3'b010: w_bundle.alucode = ALU_SLT;
                    3'b011: w_bundle.alucode = ALU_SLTU;
                    3'b100: w_bundle.alucode = ALU_XOR;
                    3'b110: w_bundle.alucode = ALU_OR;
                    3'b111: w_bundle.alucode = ALU_AND;
                    3'b001: begin
                        w_bundle.alucode = ALU_SLL;
                        w_bundle.imm     = w_immSh;
                        w_legal          = (w_f7 == 7'b0000000);
                    end
                    default: begin
                        w_bundle.imm = w_immSh;
                        if (w_f7 == 7'b0000000) begin
                            w_bundle.alucode = ALU_SRL;
                        end else if (w_f7 == 7'b0100000) begin
                            w_bundle.alucode = ALU_SRA;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                w_bundle.srcreg1_num = w_rs1;
                w_bundle.srcreg2_num = w_rs2;
                w_bundle.aluop1_type = OP_TYPE_REG;
                w_bundle.aluop2_type = OP_TYPE_REG;
                w_writes             = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_bundle.alucode = ALU_ADD;
                        3'b001:  w_bundle.alucode = ALU_SLL;
                        3'b010:  w_bundle.alucode = ALU_SLT;
                        3'b011:  w_bundle.alucode = ALU_SLTU;
                        3'b100:  w_bundle.alucode = ALU_XOR;
                        3'b101:  w_bundle.alucode = ALU_SRL;
                        3'b110:  w_bundle.alucode = ALU_OR;
                        default: w_bundle.alucode = ALU_AND;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_bundle.alucode = ALU_SUB;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_bundle.alucode = ALU_SRA;
                end else if (w_f7 == 7'b0000001 && ENABLE_M != DISABLE) begin
                    w_bundle.alucode = mAluCode(w_f3);
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_SYSTEM: begin
                if (i_ir == ECALL_WORD) begin
                    w_bundle.alucode = ALU_NOP;
                    w_bundle.is_halt = 1'b1;
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: w_legal = 1'b0;
        endcase
        w_bundle.dstreg_num = w_writes ? w_rd : 5'd0;
        w_bundle.reg_wren   = w_writes && (w_rd != 5'd0);
        if (!w_legal) begin
            w_bundle            = '0;
            w_bundle.is_illegal = 1'b1;
        end
    end

    assign o_bundle = w_bundle;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes the fetched instruction and buffers the
// bundle with its PC in a small FIFO with valid/ready on both sides and flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int ENABLE_M   = 1,
    parameter int FIFO_DEPTH = 2,
    parameter int PC_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      srcreg1_num,
    output logic [4:0]      srcreg2_num,
    output logic [4:0]      dstreg_num,
    output logic [31:0]     imm,
    output logic [5:0]      alucode,
    output logic [1:0]      aluop1_type,
    output logic [1:0]      aluop2_type,
    output logic            reg_wren,
    output logic            is_load,
    output logic            is_store,
    output logic            is_halt,
    output logic            is_illegal
);

    localparam int AW = $clog2(FIFO_DEPTH);

    bundle_t         r_mem   [FIFO_DEPTH];
    logic [PC_W-1:0] r_pcMem [FIFO_DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic            r_active;

    bundle_t         w_decoded;
    bundle_t         w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    rv_decode_comb #(
        .ENABLE_M(ENABLE_M)
    ) u_decode (
        .i_ir    (in_ir),
        .o_bundle(w_decoded)
    );

    // The wrap bit tells full (same index, different lap) from empty (identical pointers)
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign in_ready  = r_active && !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready && !flush && !rst;
    assign w_pop     = out_valid && out_ready;

    // Pointer and ready-enable state; reset beats flush, flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + (AW+1)'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + (AW+1)'(1);
                end
            end
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]]   <= w_decoded;
            r_pcMem[r_wptr[AW-1:0]] <= in_pc;
        end
    end

    assign w_head = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign out_pc = w_empty ? '0 : r_pcMem[r_rptr[AW-1:0]];

    assign srcreg1_num = w_head.srcreg1_num;
    assign srcreg2_num = w_head.srcreg2_num;
    assign dstreg_num  = w_head.dstreg_num;
    assign imm         = w_head.imm;
    assign alucode     = w_head.alucode;
    assign aluop1_type = w_head.aluop1_type;
    assign aluop2_type = w_head.aluop2_type;
    assign reg_wren    = w_head.reg_wren;
    assign is_load     = w_head.is_load;
    assign is_store    = w_head.is_store;
    assign is_halt     = w_head.is_halt;
    assign is_illegal  = w_head.is_illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I(M) instruction decode stage.
- Decodes one 32-bit instruction per cycle into the register-number / immediate / ALU-control bundle consumed by the execute stage.
- Buffers decoded bundles in a small FIFO with valid/ready handshakes on both sides, and supports a pipeline flush.
- Adds M-extension decode, illegal-instruction flagging and halt (ECALL) detection.
- Sits between fetch and execute.

Parameters:
- ENABLE_M, 1, 1 = decode MUL/DIV/REM family; 0 = flag those encodings illegal.
- FIFO_DEPTH, 2, decoded-bundle buffer entries; power of two, ≥2.
- PC_W, 32, program counter width carried alongside the instruction.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all buffered and same-cycle input instructions
- in_valid  input  1  fetch presents instruction
- in_ready  output  1  stage can accept; in_valid && in_ready = push
- in_ir  input  32  instruction word
- in_pc  input  PC_W  instruction address
- out_valid  output  1  head bundle valid
- out_ready  input  1  execute consumes; out_valid && out_ready = pop
- out_pc  output  PC_W  address of head instruction
- srcreg1_num  output  5  rs1 number
- srcreg2_num  output  5  rs2 number
- dstreg_num  output  5  rd number
- imm  output  32  sign/zero-extended immediate
- alucode  output  6  ALU operation
- aluop1_type  output  2  operand-1 source
- aluop2_type  output  2  operand-2 source
- reg_wren  output  1  write rd
- is_load  output  1  load
- is_store  output  1  store
- is_halt  output  1  ECALL (0x00000073) seen
- is_illegal  output  1  unsupported or malformed encoding

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - FIFO empty, out_valid=0, in_ready=0 while rst=1.
  - All bundle outputs 0 (alucode=0, types OP_TYPE_NONE).
  - in_ready=1 from the first cycle after rst deasserts.
- Decode is combinational on in_ir. The result is written into the FIFO on push. Bundle outputs always show the FIFO head, and are all-zero when empty.
- Latency: an instruction pushed in cycle N has out_valid=1 in cycle N+1 (empty FIFO). There is no combinational in→out path.
- in_ready = !full, derived from registered state only; it does not depend on out_ready. Push and pop in the same cycle are allowed whenever not full.
- Order is strictly FIFO. Read/write pointers wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
- flush=1:
  - Next cycle the FIFO is empty and out_valid=0.
  - A push in the same cycle is discarded.
  - flush has priority over push/pop.
  - rst has priority over flush.
- Immediates:
  - I-type: sign-extended ir[31:20].
  - Shift-immediate: zero-extended shamt ir[24:20].
  - S-type: sign-extended {ir[31:25], ir[11:7]}.
  - B-type: sign-extended 13-bit, bit0=0.
  - J-type: sign-extended 21-bit {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - U-type: {ir[31:12], 12'b0}.
  - R-type: 0.
- Operand types:
  - OP: REG/REG. OPIMM/LOAD/STORE/JALR: REG/IMM. LUI: NONE/IMM.
  - AUIPC: IMM/PC. JAL: NONE/PC. BRANCH: REG/REG.
  - Unused rs fields are forced to 0.
- reg_wren=0 whenever rd==0, and for BRANCH, STORE, illegal and halt.
- M extension: funct7=0000001 on OP maps funct3 0..7 to ALU_MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. If ENABLE_M=0, these encodings are illegal.
- Illegal: unknown opcode, or undefined funct3/funct7 combination (e.g. BRANCH funct3 010, LOAD funct3 011, SRLI funct7 ≠ 0000000/0100000). Output is alucode=0, reg_wren/is_load/is_store=0, is_illegal=1. The bundle still flows through the FIFO.
- Every output field is fully assigned for every opcode; no latches.

Decomposition:
- define.vh gains:
  - ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU (unused 6-bit codes).
  - SYSTEM opcode and the ECALL word.
  - Existing ALU_*, OP_TYPE_*, opcode and ENABLE/DISABLE defines are reused.
- Sub-module rv_decode_comb: purely combinational ir → bundle plus is_illegal/is_halt.
- decode_stage: instantiates rv_decode_comb, and owns the FIFO, handshakes and flush.

Test Plan:
- After reset, push 0xFFF10093 (addi x1,x2,-1) with out_ready=1 → next cycle out_valid=1, rs1=2, rd=1, imm=0xFFFFFFFF, alucode=ALU_ADD, types REG/IMM, reg_wren=1.
- Push 0x40335293 (srai x5,x6,3) → alucode=ALU_SRA, imm=0x00000003, rs2=0. Push 0xFFDFF06F (jal x0,-4) → alucode=ALU_JAL, imm=0xFFFFFFFC, reg_wren=0.
- Push 0x022081B3 (mul x3,x1,x2) → ENABLE_M=1: alucode=ALU_MUL, rs1=1, rs2=2, rd=3, is_illegal=0. ENABLE_M=0: is_illegal=1, reg_wren=0.
- FIFO_DEPTH=2, out_ready=0, present 3 instructions back-to-back → in_ready=0 after 2 pushes. Raise out_ready → pops in push order, third accepted next cycle.
- Two bundles buffered, assert flush together with a push → next cycle out_valid=0, in_ready=1, no flushed or same-cycle instruction emitted later.
- Push 0x00000073 → is_halt=1, reg_wren=0. Push 0x0000007F → is_illegal=1. Assert rst with a full FIFO → next cycle out_valid=0, all outputs 0.
